// File: rtl/ahb_boot_ram.sv
// ahb_boot_ram: AHB-Lite slave RAM with wait states, byte lanes, write-to-read forwarding and two-cycle ERROR
module ahb_boot_ram #(
   parameter int          ADDR_WIDTH  = 13,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [2:0]  hburst,
   input  logic [3:0]  hprot,
   input  logic        hmastlock,
   input  logic [31:0] hwdata,
   input  logic        hready,
   output logic        hreadyout,
   output logic        hresp,
   output logic [31:0] hrdata
);
   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
   localparam logic [32:0] SIZE_BYTES = 33'd4 << ADDR_WIDTH;
   localparam logic [1:0]  WS         = 2'(WAIT_STATES);
   logic [31:0]           mem [2**ADDR_WIDTH];
   state_t                state_q, state_d;
   logic [1:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d, idx_new;
   logic [3:0]            be_q, be_d, be_new;
   logic                  write_q, write_d;
   logic [31:0]           hrdata_q, hrdata_d;
   logic [31:0]           off, rd_word;
   logic                  start, legal, can_take, unused_ok;
   assign off       = haddr - BASE_ADDR;
   assign idx_new   = off[ADDR_WIDTH+1:2];
   assign can_take  = state_q inside {S_IDLE, S_DATA, S_ERR2};
   assign start     = hsel & hready & htrans[1] & can_take;
   assign legal     = ({1'b0, off} < SIZE_BYTES) && (hsize <= 3'd2) &&
                      !(hsize == 3'd1 && off[0]) && !(hsize == 3'd2 && off[1:0] != 2'd0);
   assign be_new    = hsize == 3'd0 ? 4'b0001 << off[1:0] :
                      hsize == 3'd1 ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   assign unused_ok = ^{hburst, hprot, hmastlock, htrans[0]};
   assign hreadyout = !(state_q inside {S_WAIT, S_ERR1});
   assign hresp     = state_q inside {S_ERR1, S_ERR2};
   assign hrdata    = hrdata_q;
   // Array word for a new read, with bytes of a write committing this cycle merged in
   always_comb begin
      rd_word = mem[idx_new];
      for (int i = 0; i < 4; i++)
         if (state_q == S_DATA && write_q && idx_q == idx_new && be_q[i])
            rd_word[8*i +: 8] = hwdata[8*i +: 8];
   end
   // Next-state and registered data-phase bookkeeping
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      be_d     = be_q;
      write_d  = write_q;
      hrdata_d = hrdata_q;
      case (state_q)
         S_WAIT: begin
            cnt_d    = cnt_q - 2'd1;
            state_d  = cnt_q == 2'd1 ? S_DATA : S_WAIT;
            hrdata_d = (cnt_q == 2'd1 && !write_q) ? mem[idx_q] : hrdata_q;
         end
         S_ERR1: state_d = S_ERR2;
         default: begin
            state_d = !start ? S_IDLE : !legal ? S_ERR1 : WS == 2'd0 ? S_DATA : S_WAIT;
            if (start && legal) begin
               cnt_d    = WS;
               idx_d    = idx_new;
               be_d     = be_new;
               write_d  = hwrite;
               hrdata_d = (WS == 2'd0 && !hwrite) ? rd_word : hrdata_q;
            end
         end
      endcase
   end
   // State registers; reset abandons any transfer in flight
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= 2'd0;
         idx_q    <= '0;
         be_q     <= 4'd0;
         write_q  <= 1'b0;
         hrdata_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         be_q     <= be_d;
         write_q  <= write_d;
         hrdata_q <= hrdata_d;
      end
   end
   // Commit write lanes at the end of the final data cycle; contents survive reset
   always_ff @(posedge clk) begin
      if (reset && state_q == S_DATA && write_q)
         for (int i = 0; i < 4; i++)
            if (be_q[i]) mem[idx_q][8*i +: 8] <= hwdata[8*i +: 8];
   end
endmodule
